// File: rtl/risc_rf_pkg.sv
// Shared types, defaults and helpers for the multi-port RISC-V register file.
package risc_rf_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int RF_XLEN_DEFAULT     = 32;
  localparam int RF_NUM_REGS_DEFAULT = 32;

  function automatic logic rf_addr_valid(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/risc_rf_read_port.sv
// One registered read port: x0/out-of-range zeroing, optional write bypass, output flop.
// RISC_RF_BYPASS_EN selects write-first behaviour on a same-edge address match.
module risc_rf_read_port
  import risc_rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEFAULT,
  parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_run,
  input  logic                              i_ren,
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]     i_regs,
  input  logic                              i_wr_ok,
  input  logic [ADDR_W-1:0]                 i_wr_addr,
  input  logic [XLEN-1:0]                   i_wr_data,
  output logic [XLEN-1:0]                   o_data
);

  logic [XLEN-1:0] w_rd_val;
  logic [XLEN-1:0] r_data;

  always_comb begin
    w_rd_val = '0;
    if (i_addr != '0 && rf_addr_valid(32'(i_addr), NUM_REGS))
      w_rd_val = i_regs[i_addr];
`ifdef RISC_RF_BYPASS_EN
    // i_wr_ok already excludes x0, out-of-range and CLEAR, so a match is always a legal write
    if (i_wr_ok && i_wr_addr == i_addr)
      w_rd_val = i_wr_data;
`endif
  end

`ifndef RISC_RF_BYPASS_EN
  logic w_unused_byp;
  assign w_unused_byp = ^{i_wr_ok, i_wr_addr, i_wr_data};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_data <= '0;
    else if (i_run && i_ren)
      r_data <= w_rd_val;
  end

  assign o_data = r_data;

endmodule

// File: rtl/risc_regfile_multiport.sv
// RISC-V integer register file: NUM_READ registered read ports, one write port, x0 hardwired,
// post-reset sequential clear. Define RISC_RF_BYPASS_EN for write-first same-edge reads.
module risc_regfile_multiport
  import risc_rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEFAULT,
  parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
  parameter int NUM_READ = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] rs_addr,
  input  logic                       read_enable,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [XLEN-1:0]            rd_data,
  input  logic                       write_enable,
  output logic [NUM_READ*XLEN-1:0]   rs_data,
  output logic                       ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  rf_state_t                     r_state, w_state_nxt;
  logic [ADDR_W-1:0]             r_clr_idx, w_clr_idx_nxt;
  logic [NUM_REGS-1:0][XLEN-1:0] r_regs;
  logic                          w_run;
  logic                          w_wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= ADDR_W'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      RF_CLEAR: begin
        if (r_clr_idx == LAST_IDX) w_state_nxt   = RF_RUN;
        else                       w_clr_idx_nxt = r_clr_idx + 1'b1;
      end
      default: w_state_nxt = RF_RUN;
    endcase
  end

  assign w_run   = (r_state == RF_RUN);
  assign ready   = w_run;
  assign w_wr_ok = w_run && write_enable && rd != '0 && rf_addr_valid(32'(rd), NUM_REGS);

  // Entry 0 is never written; every read port masks it to zero.
  always_ff @(posedge clk) begin
    if (!w_run)
      r_regs[r_clr_idx] <= '0;
    else if (w_wr_ok)
      r_regs[rd] <= rd_data;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rp
    risc_rf_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_rp (
      .clk       (clk),
      .reset     (reset),
      .i_run     (w_run),
      .i_ren     (read_enable),
      .i_addr    (rs_addr[p*ADDR_W +: ADDR_W]),
      .i_regs    (r_regs),
      .i_wr_ok   (w_wr_ok),
      .i_wr_addr (rd),
      .i_wr_data (rd_data),
      .o_data    (rs_data[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_risc_regfile_multiport.sv
// Scoreboard bench: a 32-entry and a 20-entry register file share one stimulus stream,
// each checked against its own array-based reference model.
module tb_risc_regfile_multiport;
  localparam int XL = 32;
  localparam int AW = 5;
`ifdef RISC_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2*AW-1:0] rs_addr = '0;
  logic            read_enable = 1'b0;
  logic            write_enable = 1'b0;
  logic [AW-1:0]   rd = '0;
  logic [XL-1:0]   rd_data = '0;
  logic [2*XL-1:0] rs_data_a, rs_data_b;
  logic            ready_a, ready_b;

  always #5 clk = ~clk;

  risc_regfile_multiport #(.XLEN(XL), .NUM_REGS(32), .NUM_READ(2)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .read_enable(read_enable), .rd(rd),
    .rd_data(rd_data), .write_enable(write_enable), .rs_data(rs_data_a), .ready(ready_a));

  risc_regfile_multiport #(.XLEN(XL), .NUM_REGS(20), .NUM_READ(2)) dut20 (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .read_enable(read_enable), .rd(rd),
    .rd_data(rd_data), .write_enable(write_enable), .rs_data(rs_data_b), .ready(ready_b));

  typedef struct packed {
    logic [1:0]           rdy;
    logic [1:0][2*XL-1:0] d;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              failures = 0;
  logic [XL-1:0]   mem [2][32];
  int              cnt [2];
  logic [2*XL-1:0] dat [2];
  int              nr  [2] = '{32, 20};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and predict both DUTs' outputs after the coming edge.
  task automatic step(input logic rst, input logic ren, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic we, input logic [AW-1:0] wa,
                      input logic [XL-1:0] wd);
    exp_t          e;
    logic [AW-1:0] a;
    logic [XL-1:0] v;
    logic          hit;
    @(negedge clk);
    reset = rst; read_enable = ren; rs_addr = {a1, a0};
    write_enable = we; rd = wa; rd_data = wd;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k] = nr[k] - 1;
        dat[k] = '0;
        for (int i = 0; i < 32; i++) mem[k][i] = '0;
      end else if (cnt[k] > 0) begin
        cnt[k]--;
      end else begin
        hit = we && wa != 0 && int'(wa) < nr[k];
        if (ren) begin
          for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? a0 : a1;
            v = (a != 0 && int'(a) < nr[k]) ? mem[k][a] : '0;
            if (BYP && hit && wa == a) v = wd;
            dat[k][p*XL +: XL] = v;
          end
        end
        if (hit) mem[k][wa] = wd;
      end
      e.rdy[k] = !rst && cnt[k] == 0;
      e.d[k]   = dat[k];
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  // Count edges from reset release until each DUT first shows ready.
  task automatic clear_time(input string nm);
    int hi_a = -1, hi_b = -1;
    for (int i = 1; i <= 40; i++) begin
      idle(1'b0);
      after_edge();
      if (ready_a && hi_a < 0) hi_a = i;
      if (ready_b && hi_b < 0) hi_b = i;
    end
    chk({nm, "_clear32"}, 64'(hi_a), 64'd31);
    chk({nm, "_clear20"}, 64'(hi_b), 64'd19);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready32", 64'(ready_a), 64'(e.rdy[0]));
        chk("ready20", 64'(ready_b), 64'(e.rdy[1]));
        chk("rs_data32", rs_data_a, e.d[0]);
        chk("rs_data20", rs_data_b, e.d[1]);
      end
    end
  end

  initial begin : driver
    logic [AW-1:0] a0, a1, wa;
    // T1: reset, clear duration, all registers read back zero
    repeat (3) idle(1'b1);
    after_edge();
    chk("reset_rs_data", rs_data_a, 64'd0);
    chk("reset_ready", 64'(ready_a), 64'd0);
    clear_time("t1");
    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, AW'(i), AW'(i), 1'b0, '0, '0);

    // T2: write then read {x0,x5}
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 32'hDEADBEEF);
    step(1'b0, 1'b1, AW'(0), AW'(5), 1'b0, '0, '0);
    after_edge();
    chk("t2_port1", 64'(rs_data_a[63:32]), 64'hDEADBEEF);
    chk("t2_port0", 64'(rs_data_a[31:0]), 64'd0);

    // T3: x0 write is dropped
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 32'hFFFFFFFF);
    step(1'b0, 1'b1, AW'(0), AW'(0), 1'b0, '0, '0);
    after_edge();
    chk("t3_x0", rs_data_a, 64'd0);

    // T4: hold with read_enable low
    step(1'b0, 1'b1, AW'(5), AW'(5), 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, AW'(6), AW'(6), 1'b0, '0, '0);
      after_edge();
      chk("t4_hold", 64'(rs_data_a[31:0]), 64'hDEADBEEF);
    end

    // T5: same-edge read/write
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), 32'd1);
    step(1'b0, 1'b1, AW'(7), AW'(7), 1'b1, AW'(7), 32'd2);
    after_edge();
    chk("t5_same_edge", 64'(rs_data_a[31:0]), BYP ? 64'd2 : 64'd1);
    step(1'b0, 1'b1, AW'(7), AW'(7), 1'b0, '0, '0);
    after_edge();
    chk("t5_next_read", 64'(rs_data_a[31:0]), 64'd2);

    // T6: reset at clr_idx=10 restarts the full clear
    repeat (2) idle(1'b1);
    repeat (9) idle(1'b0);
    repeat (2) idle(1'b1);
    clear_time("t6");
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 32'hAA);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(25), 32'd5);
    step(1'b0, 1'b1, AW'(25), AW'(5), 1'b0, '0, '0);
    after_edge();
    chk("t6_oor_read20", 64'(rs_data_b[31:0]), 64'd0);
    chk("t6_x5_intact20", 64'(rs_data_b[63:32]), 64'hAA);
    chk("t6_x25_read32", 64'(rs_data_a[31:0]), 64'd5);

    // Random traffic, biased toward a few addresses to provoke collisions
    for (int i = 0; i < 400; i++) begin
      a0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) != 0) ? a0 : AW'($urandom_range(0, 31));
      step(1'b0, $urandom_range(0, 9) < 7, a0, a1, $urandom_range(0, 9) < 6, wa, $urandom);
    end

    repeat (3) idle(1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
